single_port_ram: RTL and testbench

SINGLE_PORT_RAM -- requirements
Module: single_port_ram

---
 rtl/spram_pkg.sv | 7 +
 rtl/single_port_ram.sv | 50 +++++
 tb/tb_single_port_ram.sv | 124 ++++++++++++
 3 files changed

// File: rtl/spram_pkg.sv
// Shared default geometry for the single-port RAM.
package spram_pkg;

    localparam int SPRAM_DATA_WIDTH = 8;
    localparam int SPRAM_ADDR_WIDTH = 6;

endpackage : spram_pkg

// File: rtl/single_port_ram.sv
// Single-port synchronous RAM: one read or write per cycle, registered read data.
// Reset clears only the output register; the array stays reset-free so it maps onto RAM.
module single_port_ram
    import spram_pkg::*;
#(
    parameter int DATA_WIDTH = SPRAM_DATA_WIDTH,
    parameter int ADDR_WIDTH = SPRAM_ADDR_WIDTH,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  en,
    input  logic                  write_enable,
    input  logic                  clk,
    output logic [DATA_WIDTH-1:0] q,
    input  logic                  rst_n
);

    generate
        if (DEPTH < 1 || DEPTH > 2 ** ADDR_WIDTH) begin : g_depth_check
            $error("single_port_ram: DEPTH must be in 1..2**ADDR_WIDTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic wr_access;
    logic rd_access;
    logic wr_commit;

    assign wr_access = en && write_enable;
    assign rd_access = en && !write_enable;
    // Writes are dropped while reset is held so the array is untouched by reset activity.
    assign wr_commit = wr_access && rst_n;

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[address] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (rd_access) begin
            q <= mem[address];
        end
    end

endmodule : single_port_ram

// File: tb/tb_single_port_ram.sv
// Directed, table-driven check of the single-port RAM plus a hand-written reset sequence.
module tb_single_port_ram;

    logic [7:0] data;
    logic [5:0] address;
    logic       en;
    logic       write_enable;
    logic       clk;
    logic [7:0] q;
    logic       rst_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       en;
        logic       we;
        logic [5:0] addr;
        logic [7:0] data;
        logic [7:0] exp_q;
        string      name;
    } vec_t;

    vec_t vecs[$];

    single_port_ram dut (
        .data         (data),
        .address      (address),
        .en           (en),
        .write_enable (write_enable),
        .clk          (clk),
        .q            (q),
        .rst_n        (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] exp_q);
        checks++;
        if (q !== exp_q) begin
            failures++;
            $display("FAIL %s: q=%h expected=%h", name, q, exp_q);
        end else begin
            $display("ok   %s: q=%h", name, q);
        end
    endtask

    task automatic add(input logic e, input logic w, input logic [5:0] a,
                       input logic [7:0] d, input logic [7:0] x, input string n);
        vec_t v;
        v.en = e; v.we = w; v.addr = a; v.data = d; v.exp_q = x; v.name = n;
        vecs.push_back(v);
    endtask

    // Drive between edges, sample 1 time unit after the active edge.
    task automatic cycle(input logic e, input logic w, input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        en = e; write_enable = w; address = a; data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; write_enable = 1'b0; address = '0; data = '0;

        add(1, 1, 6'd16, 8'h18, 8'h00, "wr16_no_writethrough");
        add(1, 1, 6'd12, 8'h29, 8'h00, "wr12_no_writethrough");
        add(1, 1, 6'd7,  8'hAA, 8'h00, "wr7_no_writethrough");
        add(1, 0, 6'd16, 8'h00, 8'h18, "rd16");
        add(1, 0, 6'd12, 8'h00, 8'h29, "rd12");
        add(1, 0, 6'd7,  8'h00, 8'hAA, "rd7");
        add(1, 0, 6'd16, 8'h00, 8'h18, "rd16_again");
        add(0, 0, 6'd12, 8'h00, 8'h18, "en_low_addr_change");
        add(0, 1, 6'd12, 8'h77, 8'h18, "en_low_write_ignored");
        add(1, 0, 6'd12, 8'h00, 8'h29, "rd12_after_blocked_write");
        add(1, 1, 6'd63, 8'h55, 8'h29, "wr63_hold");
        add(1, 1, 6'd0,  8'h66, 8'h29, "wr0_hold");
        add(1, 0, 6'd63, 8'h00, 8'h55, "rd63_boundary");
        add(1, 0, 6'd0,  8'h00, 8'h66, "rd0_boundary");
        add(1, 1, 6'd5,  8'h01, 8'h66, "wr5_first_hold");
        add(1, 1, 6'd5,  8'h02, 8'h66, "wr5_second_hold");
        add(1, 0, 6'd5,  8'h00, 8'h02, "rd5_last_write_wins");
        add(1, 1, 6'd9,  8'hC3, 8'h02, "wr9_hold");
        add(1, 0, 6'd9,  8'h00, 8'hC3, "rd9_after_write");

        // Reset state and first access right after release.
        repeat (2) @(posedge clk);
        #1;
        check("reset_q_zero", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].data);
            check(vecs[i].name, vecs[i].exp_q);
        end

        // Asynchronous reset mid-cycle: q clears without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 8'h00);

        // Accesses while reset is held are ignored.
        cycle(1, 1, 6'd12, 8'hEE);
        check("reset_write_ignored_q", 8'h00);
        cycle(1, 0, 6'd16, 8'h00);
        check("reset_read_ignored_q", 8'h00);

        // Release between edges; the next edge must accept the read.
        #2;
        rst_n = 1'b1;
        cycle(1, 0, 6'd12, 8'h00);
        check("post_reset_rd12_preserved", 8'h29);
        cycle(1, 0, 6'd63, 8'h00);
        check("post_reset_rd63_preserved", 8'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_single_port_ram
